alu_share_arb: RTL
==================

Name: alu_share_arb

Overview:
- Shares one combinational `alu` instance between two requesters, e.g. the EX-stage integer path and a second issue slot or address-calc path.
- Handles per-requester valid/ready request and response channels, round-robin grant, one issue-register pipeline stage, and a depth-1 result buffer per requester.
- Result latency is 2 cycles from accept to rsp_valid.

Parameters:
- TAG_W, 4, width of the opaque tag carried from request to response.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- resetn  in  1  reset, asynchronous assert, active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_aluop  in  6  ALU op code, in the `alu` encoding.
- req0_src1  in  32  vsrc1 operand (shift amount in [4:0] for shifts).
- req0_src2  in  32  vsrc2 operand.
- req0_tag  in  TAG_W  returned unchanged on rsp0_tag.
- rsp0_valid  out  1  result 0 available.
- rsp0_ready  in  1  consumer 0 takes the result.
- rsp0_result  out  32  ALU result.
- rsp0_tag  out  TAG_W  tag of that result.
- req1_*/rsp1_*: identical set for requester 1.

Behaviour:
- Reset (resetn=0, async): s1_valid=0, rsp0_valid=rsp1_valid=0, rsp*_result=0, rsp*_tag=0, rr_last=1 (requester 0 wins the first conflict). Any in-flight operation is dropped; no response is produced for it.
- Eligibility: elig_i = reqi_valid & ~(s1_valid & s1_src==i) & (~rspi_valid | rspi_ready).
  - Consequence: one requester alone issues at most every 2nd cycle.
  - Alternating requesters sustain 1 op/cycle.
- Grant:
  - Only one elig: that one is granted.
  - Both elig: the one != rr_last is granted.
  - rr_last updates only on a grant.
  - reqi_ready = grant_i. It is combinational from valid and state and never depends on reqi_aluop or operands.
- Issue stage (cycle T, accept): s1_valid<=1, s1_src<=i, and s1_aluop/s1_vsrc1/s1_vsrc2/s1_tag<=reqi_* . With no grant, s1_valid<=0.
- Execute stage (cycle T+1): `alu` sees s1_aluop, s1_vsrc1, s1_vsrc2 combinationally.
  - On the edge ending T+1: rsp[s1_src]_valid<=1, result<=alu result, tag<=s1_tag.
  - rsp valid is therefore visible in cycle T+2.
- Response hold:
  - rspi_valid, result and tag hold stable until rspi_valid & rspi_ready.
  - Then rspi_valid<=0, unless the same edge loads a new result for i; the load wins and valid stays 1.
- Buffer overflow is impossible by construction: elig_i guarantees out buffer i is free when S1 writes it. Assert this in the bench.
- Undefined aluop: passed through unchanged; `alu` yields 0, so rsp carries result 0 with the correct tag. No error flag.
- Requester may deassert reqi_valid or change operands while not ready; nothing is captured until the ready cycle.
- No combinational path from rspi_ready to rspi_valid/result.
- rspi_ready→reqi_ready path exists (drain bypass) and is intended.

Decomposition:
- Shared package alu_pkg:
  - ALUOP_W=6 and named aluop constants (ADD 6'b100000, ADDU 6'b100001, SUBU 6'b100011, SLT 6'b101010, SLTU 6'b101011, AND 6'b100100, OR 6'b100101, XOR 6'b100110, NOR 6'b100111, SLL 6'b000000, SRL 6'b000010, SRA 6'b000011, LUI 6'b001111).
  - Typedef of the issue-register struct.
- Sub-module rr_arb2: 2-way round-robin with elig[1:0] in, grant[1:0] out, rr_last state. The existing `alu` is instantiated unchanged.

Test Plan:
- Single op: req0 ADDU src1=5 src2=7 tag=3 at T → req0_ready=1 at T; rsp0_valid=1, result=12, tag=3 at T+2.
- Conflict after reset: both valid at T (req0 SLT 0xFFFFFFFF,1; req1 SLTU 0xFFFFFFFF,1) → req0 granted T, req1 T+1; rsp0=1 at T+2, rsp1=0 at T+3; rr_last ends at 1.
- Backpressure: rsp0_ready=0 holding result 12; req0 valid → req0_ready=0 until rsp0_ready=1. Then drain and accept occur in the same cycle and a new result appears 2 cycles later.
- Alternating stream: 8 ops alternating req0/req1 with ready held 1 → one accept per cycle, all results and tags correct and in per-requester order.
- Shifts and LUI: SRA src1=4 src2=0x80000000 → 0xF8000000; SRL same → 0x08000000; LUI src2=0x1234 → 0x12340000. Undefined aluop 6'b111111 → result 0, tag preserved.
- Reset mid-flight: resetn low the cycle after accept → rsp*_valid=0 immediately and stay 0 after release; the next conflict goes to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and the issue-register layout used
// by the shared-ALU arbiter.
package alu_pkg;

    localparam int ALUOP_W = 6;

    localparam logic [ALUOP_W-1:0] ALU_ADD  = 6'b100000;
    localparam logic [ALUOP_W-1:0] ALU_ADDU = 6'b100001;
    localparam logic [ALUOP_W-1:0] ALU_SUBU = 6'b100011;
    localparam logic [ALUOP_W-1:0] ALU_SLT  = 6'b101010;
    localparam logic [ALUOP_W-1:0] ALU_SLTU = 6'b101011;
    localparam logic [ALUOP_W-1:0] ALU_AND  = 6'b100100;
    localparam logic [ALUOP_W-1:0] ALU_OR   = 6'b100101;
    localparam logic [ALUOP_W-1:0] ALU_XOR  = 6'b100110;
    localparam logic [ALUOP_W-1:0] ALU_NOR  = 6'b100111;
    localparam logic [ALUOP_W-1:0] ALU_SLL  = 6'b000000;
    localparam logic [ALUOP_W-1:0] ALU_SRL  = 6'b000010;
    localparam logic [ALUOP_W-1:0] ALU_SRA  = 6'b000011;
    localparam logic [ALUOP_W-1:0] ALU_LUI  = 6'b001111;

    // Tag lives outside the struct because its width is a module parameter.
    typedef struct packed {
        logic               valid;
        logic               src;
        logic [ALUOP_W-1:0] aluop;
        logic [31:0]        vsrc1;
        logic [31:0]        vsrc2;
    } issue_t;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; shifts take their amount from vsrc1[4:0],
// unknown opcodes produce zero.
module alu
    import alu_pkg::*;
(
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic [31:0]        vsrc1,
    input  logic [31:0]        vsrc2,
    output logic [31:0]        alu_result
);

    logic [4:0] sa_s;
    assign sa_s = vsrc1[4:0];

    // Opcode decode and result select.
    always_comb begin
        alu_result = 32'h0000_0000;
        case (alu_op)
            ALU_ADD,
            ALU_ADDU: alu_result = vsrc1 + vsrc2;
            ALU_SUBU: alu_result = vsrc1 - vsrc2;
            ALU_SLT:  alu_result = {31'd0, ($signed(vsrc1) < $signed(vsrc2))};
            ALU_SLTU: alu_result = {31'd0, (vsrc1 < vsrc2)};
            ALU_AND:  alu_result = vsrc1 & vsrc2;
            ALU_OR:   alu_result = vsrc1 | vsrc2;
            ALU_XOR:  alu_result = vsrc1 ^ vsrc2;
            ALU_NOR:  alu_result = ~(vsrc1 | vsrc2);
            ALU_SLL:  alu_result = vsrc2 << sa_s;
            ALU_SRL:  alu_result = vsrc2 >> sa_s;
            ALU_SRA:  alu_result = $unsigned($signed(vsrc2) >>> sa_s);
            ALU_LUI:  alu_result = {vsrc2[15:0], 16'h0000};
            default:  alu_result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; after reset requester 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] elig,
    output logic [1:0] grant
);

    logic rr_last_r;

    // Grant: a lone eligible requester wins, a tie goes to the one not served last.
    always_comb begin
        grant = 2'b00;
        case (elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_last_r ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Remember the last granted requester; idle cycles leave it untouched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_last_r <= 1'b1;
        end else if (grant[1]) begin
            rr_last_r <= 1'b1;
        end else if (grant[0]) begin
            rr_last_r <= 1'b0;
        end else begin
            rr_last_r <= rr_last_r;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between two valid/ready requesters: arbitration, one issue
// register, and a one-entry result buffer per requester (accept -> rsp in 2).
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [ALUOP_W-1:0] req0_aluop,
    input  logic [31:0]        req0_src1,
    input  logic [31:0]        req0_src2,
    input  logic [TAG_W-1:0]   req0_tag,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic [31:0]        rsp0_result,
    output logic [TAG_W-1:0]   rsp0_tag,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [ALUOP_W-1:0] req1_aluop,
    input  logic [31:0]        req1_src1,
    input  logic [31:0]        req1_src2,
    input  logic [TAG_W-1:0]   req1_tag,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [31:0]        rsp1_result,
    output logic [TAG_W-1:0]   rsp1_tag
);

    issue_t           s1_r;
    logic [TAG_W-1:0] s1_tag_r;
    logic [1:0]       elig_s;
    logic [1:0]       grant_s;
    logic [1:0]       load_s;
    logic [31:0]      alu_res_s;

    logic             rsp0_valid_r, rsp1_valid_r;
    logic [31:0]      rsp0_result_r, rsp1_result_r;
    logic [TAG_W-1:0] rsp0_tag_r, rsp1_tag_r;

    // A requester may issue only if its op is not already in S1 and its
    // result buffer is empty or draining this cycle; this keeps the buffer
    // free when S1 writes it one cycle later.
    assign elig_s[0] = req0_valid & ~(s1_r.valid & (s1_r.src == 1'b0))
                     & (~rsp0_valid_r | rsp0_ready);
    assign elig_s[1] = req1_valid & ~(s1_r.valid & (s1_r.src == 1'b1))
                     & (~rsp1_valid_r | rsp1_ready);

    rr_arb2 u_arb (
        .clk    (clk),
        .resetn (resetn),
        .elig   (elig_s),
        .grant  (grant_s)
    );

    assign req0_ready = grant_s[0];
    assign req1_ready = grant_s[1];

    // Issue register: capture the granted request, otherwise go idle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_r     <= '0;
            s1_tag_r <= '0;
        end else if (grant_s[1]) begin
            s1_r     <= '{valid: 1'b1, src: 1'b1, aluop: req1_aluop,
                          vsrc1: req1_src1, vsrc2: req1_src2};
            s1_tag_r <= req1_tag;
        end else if (grant_s[0]) begin
            s1_r     <= '{valid: 1'b1, src: 1'b0, aluop: req0_aluop,
                          vsrc1: req0_src1, vsrc2: req0_src2};
            s1_tag_r <= req0_tag;
        end else begin
            s1_r.valid <= 1'b0;
        end
    end

    alu u_alu (
        .alu_op     (s1_r.aluop),
        .vsrc1      (s1_r.vsrc1),
        .vsrc2      (s1_r.vsrc2),
        .alu_result (alu_res_s)
    );

    assign load_s[0] = s1_r.valid & (s1_r.src == 1'b0);
    assign load_s[1] = s1_r.valid & (s1_r.src == 1'b1);

    // Result buffers: a new load wins over a drain on the same edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp0_valid_r  <= 1'b0;
            rsp0_result_r <= 32'h0000_0000;
            rsp0_tag_r    <= '0;
            rsp1_valid_r  <= 1'b0;
            rsp1_result_r <= 32'h0000_0000;
            rsp1_tag_r    <= '0;
        end else begin
            if (load_s[0]) begin
                rsp0_valid_r  <= 1'b1;
                rsp0_result_r <= alu_res_s;
                rsp0_tag_r    <= s1_tag_r;
            end else if (rsp0_valid_r & rsp0_ready) begin
                rsp0_valid_r  <= 1'b0;
            end else begin
                rsp0_valid_r  <= rsp0_valid_r;
            end
            if (load_s[1]) begin
                rsp1_valid_r  <= 1'b1;
                rsp1_result_r <= alu_res_s;
                rsp1_tag_r    <= s1_tag_r;
            end else if (rsp1_valid_r & rsp1_ready) begin
                rsp1_valid_r  <= 1'b0;
            end else begin
                rsp1_valid_r  <= rsp1_valid_r;
            end
        end
    end

    assign rsp0_valid  = rsp0_valid_r;
    assign rsp0_result = rsp0_result_r;
    assign rsp0_tag    = rsp0_tag_r;
    assign rsp1_valid  = rsp1_valid_r;
    assign rsp1_result = rsp1_result_r;
    assign rsp1_tag    = rsp1_tag_r;

endmodule
